instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Program-counter / fetch stage sitting directly upstream of the control decoder.
//  Holds PC, drives instruction-memory address, forwards the 9-bit word to decode,
//  resolves decoder branch requests (Branch, targetLUT) against a 16-entry target LUT
//  and the sc condition flag, and runs a Start/Done program-execution handshake.
// PARAMETERS
//  PCW        10      PC / imem address width; LUT entries are PCW bits
//  IW         9       instruction width (matches decoder machine-code width)
//  HALT_CODE  9'h000  fetched word that ends the program (not decoded by control)
//  CNTW       16      retired-instruction counter width
// PORTS
//  Clk        in   1      clock, all state on rising edge
//  Reset_n    in   1      asynchronous active-low reset
//  Start      in   1      begin program at PC=0 (level sampled per cycle)
//  Done       out  1      program reached HALT_CODE; held until next Start
//  run        out  1      1 while state==RUN; downstream gates regWrite/storeMem with it
//  imem_addr  out  PCW    instruction memory address (= PC), combinational ROM read
//  imem_data  in   IW     instruction word at imem_addr
//  instr      out  IW     imem_data forwarded to decoder when run=1, else 0 (no-op)
//  Branch     in   2      from decoder: 00 none, 01 jump if sc, 10 jump if !sc, 11 always
//  targetLUT  in   4      from decoder: LUT index for branch target
//  sc_flag    in   1      current special/condition bit
//  lut_we     in   1      LUT write strobe (honoured only when run=0)
//  lut_idx    in   4      LUT write index
//  lut_data   in   PCW    LUT write data (absolute target address)
//  icount     out  CNTW   instructions retired since last Start
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE, PC=0, all 16 LUT entries=0, icount=0, Done=0,
//   run=0, instr=0. Reset mid-RUN aborts immediately; no partial update survives.
//  FSM states IDLE, RUN, HALT:
//   IDLE: Start=1 -> RUN, PC<=0, icount<=0. Else hold.
//   RUN : if imem_data==HALT_CODE -> HALT, PC holds, icount unchanged (halt not counted),
//         Branch ignored. Else PC<=next_pc, icount<=icount+1 (saturates at all-ones).
//         Start ignored while RUN.
//   HALT: Done=1. Start=1 -> RUN, PC<=0, icount<=0, Done<=0 same edge. Else hold.
//  next_pc: taken = (Branch==11)|(Branch==01 & sc_flag)|(Branch==10 & !sc_flag);
//   taken -> lut[targetLUT]; else PC+1 modulo 2^PCW (PC=2^PCW-1 wraps to 0).
//  Single-cycle: decode and resolution of word at PC complete in the cycle it is
//   addressed; the new PC takes effect on the next rising edge (zero bubble).
//  LUT: write on rising edge when lut_we=1 and state!=RUN; writes in RUN dropped.
//   No read-after-write bypass needed (reads only occur in RUN).
//  Done, run are registered state decodes (no combinational path from Start).
//  Outside RUN, Branch/sc_flag have no effect; instr forced to 0 so decoder sees no-op.
// TESTING
//  1 Reset: pulse Reset_n low mid-RUN at PC=5 -> same cycle PC=0, run=0, Done=0, LUT[0..15]=0.
//  2 Straight-line: ROM 0..3 non-branch, ROM[4]=HALT_CODE, Start 1 cycle -> imem_addr 0,1,2,3,4,
//    Done=1 on cycle after PC=4, icount=4, PC stays 4.
//  3 Branches: LUT[3]=20; PC=2 with Branch=01,targetLUT=3: sc=1 -> PC=20; sc=0 -> PC=3;
//    Branch=10,sc=0 -> PC=20; Branch=11 -> PC=20 regardless of sc.
//  4 LUT guard: lut_we with idx=7,data=9 in RUN -> LUT[7] unchanged; same write in IDLE -> LUT[7]=9.
//  5 Wrap: PCW=4, no HALT in ROM, Start -> PC sequence ...14,15,0,1; icount keeps counting.
//  6 Restart: in HALT assert Start -> next edge Done=0, run=1, PC=0, icount=0; Start held in RUN ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Program-counter / fetch stage feeding the control decoder. Holds the PC,
//   presents it as the instruction-memory address, forwards the fetched word
//   to decode while running, resolves decoder branch requests through a
//   16-entry absolute-target LUT and the sc condition flag, and runs a
//   Start/Done program handshake with an IDLE/RUN/HALT state machine.
//
// Ports
//   Clk        in   1     clock, all state updates on the rising edge
//   Reset_n    in   1     asynchronous active-low reset
//   Start      in   1     start program at PC=0 (sampled each cycle, IDLE/HALT)
//   Done       out  1     program fetched HALT_CODE; held until next Start
//   run        out  1     high while executing; gates downstream writes
//   imem_addr  out  PCW   instruction memory address (equals PC)
//   imem_data  in   IW    instruction word at imem_addr
//   instr      out  IW    imem_data while running, otherwise all-zero no-op
//   Branch     in   2     00 none, 01 if sc, 10 if !sc, 11 always
//   targetLUT  in   4     LUT index of the branch target
//   sc_flag    in   1     condition bit used by conditional branches
//   lut_we     in   1     LUT write strobe (ignored while running)
//   lut_idx    in   4     LUT write index
//   lut_data   in   PCW   LUT write data (absolute target address)
//   icount     out  CNTW  instructions retired since last Start (saturating)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int              PCW       = 10,
  parameter int              IW        = 9,
  parameter logic [IW-1:0]   HALT_CODE = {IW{1'b0}},
  parameter int              CNTW      = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  output logic             Done,
  output logic             run,
  output logic [PCW-1:0]   imem_addr,
  input  logic [IW-1:0]    imem_data,
  output logic [IW-1:0]    instr,
  input  logic [1:0]       Branch,
  input  logic [3:0]       targetLUT,
  input  logic             sc_flag,
  input  logic             lut_we,
  input  logic [3:0]       lut_idx,
  input  logic [PCW-1:0]   lut_data,
  output logic [CNTW-1:0]  icount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [PCW-1:0]  PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PCW-1:0]  lut_q [16];

  logic            is_halt_s;
  logic            taken_s;
  logic [PCW-1:0]  next_pc_s;
  logic [CNTW-1:0] cnt_inc_s;

  // Branch resolution and sequential PC for the word currently addressed.
  always_comb begin
    is_halt_s = (imem_data == HALT_CODE);
    case (Branch)
      2'b01:   taken_s = sc_flag;
      2'b10:   taken_s = ~sc_flag;
      2'b11:   taken_s = 1'b1;
      default: taken_s = 1'b0;
    endcase
    if (taken_s) begin
      next_pc_s = lut_q[targetLUT];
    end else begin
      // Natural modulo-2^PCW wrap.
      next_pc_s = pc_q + PC_ONE;
    end
    if (cnt_q == {CNTW{1'b1}}) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // State, PC and retired-count registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= {PCW{1'b0}};
      cnt_q   <= {CNTW{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic for FSM, PC and counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = {PCW{1'b0}};
          cnt_d   = {CNTW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // The halt word is not retired and any branch on it is ignored.
        if (is_halt_s) begin
          state_d = S_HALT;
        end else begin
          pc_d  = next_pc_s;
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = {PCW{1'b0}};
        cnt_d   = {CNTW{1'b0}};
      end
    endcase
  end

  // Outputs decode only registered state, so Start has no combinational path.
  always_comb begin
    run       = (state_q == S_RUN);
    Done      = (state_q == S_HALT);
    imem_addr = pc_q;
    icount    = cnt_q;
    if (state_q == S_RUN) begin
      instr = imem_data;
    end else begin
      instr = {IW{1'b0}};
    end
  end

  // Branch target LUT; loading is locked out while the program runs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        lut_q[i] <= {PCW{1'b0}};
      end
    end else begin
      if (lut_we && (state_q != S_RUN)) begin
        lut_q[lut_idx] <= lut_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done;
  logic        run;
  logic [9:0]  addr;
  logic [8:0]  data;
  logic [8:0]  instr;
  logic [1:0]  branch;
  logic [3:0]  tlut;
  logic        sc;
  logic        lut_we;
  logic [3:0]  lut_idx;
  logic [9:0]  lut_data;
  logic [15:0] icount;

  logic        start2;
  logic        done2;
  logic        run2;
  logic [3:0]  addr2;
  logic [8:0]  data2;
  logic [8:0]  instr2;
  logic [15:0] icount2;

  logic [8:0]  rom  [1024];
  logic [8:0]  rom2 [16];

  int errors;
  int checks;

  assign data  = rom[addr];
  assign data2 = rom2[addr2];

  instr_fetch #(.PCW(10), .IW(9), .HALT_CODE(9'h000), .CNTW(16)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Done(done), .run(run),
    .imem_addr(addr), .imem_data(data), .instr(instr),
    .Branch(branch), .targetLUT(tlut), .sc_flag(sc),
    .lut_we(lut_we), .lut_idx(lut_idx), .lut_data(lut_data), .icount(icount)
  );

  instr_fetch #(.PCW(4), .IW(9), .HALT_CODE(9'h000), .CNTW(16)) dut_wrap (
    .Clk(clk), .Reset_n(rst_n), .Start(start2), .Done(done2), .run(run2),
    .imem_addr(addr2), .imem_data(data2), .instr(instr2),
    .Branch(2'b00), .targetLUT(4'h0), .sc_flag(1'b0),
    .lut_we(1'b0), .lut_idx(4'h0), .lut_data(4'h0), .icount(icount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until Done rises or the cycle budget expires.
  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (!done && n < 30) begin
      step();
      n++;
    end
    ok = done;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bit ok;
    checks++;
    if (done !== 1'b0 || run !== 1'b0 || addr !== 10'd0 || icount !== 16'd0 || instr !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: done=%b run=%b addr=%0d icount=%0d instr=%h, want 0 0 0 0 000",
               done, run, addr, icount, instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      lut_we = 1'b1; lut_idx = 4'(k); lut_data = 10'(k + 100);
      step();
    end
    lut_we = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    checks++;
    if (addr !== 10'd5 || run !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun: addr=%0d run=%b, want 5 1", addr, run);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (addr !== 10'd0 || run !== 1'b0 || done !== 1'b0 || icount !== 16'd0) begin
      errors++;
      $display("FAIL reset_async: addr=%0d run=%b done=%b icount=%0d, want 0 0 0 0",
               addr, run, done, icount);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      branch = 2'b11; tlut = 4'(k);
      step();
      checks++;
      if (addr !== 10'd0) begin
        errors++;
        $display("FAIL reset_lut%0d: branched to %0d, want 0", k, addr);
      end
    end
    branch = 2'b00;
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_halt_timeout: done=%b, want 1", done);
    end
  endtask

  task automatic test_straight();
    rom[4] = 9'h000;
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (addr !== 10'd0 || run !== 1'b1 || instr !== 9'h1A5) begin
      errors++;
      $display("FAIL straight_first: addr=%0d run=%b instr=%h, want 0 1 1a5", addr, run, instr);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (addr !== 10'(i) || done !== 1'b0) begin
        errors++;
        $display("FAIL straight_pc%0d: addr=%0d done=%b, want %0d 0", i, addr, done, i);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || run !== 1'b0 || icount !== 16'd4 || addr !== 10'd4 || instr !== 9'd0) begin
      errors++;
      $display("FAIL straight_halt: done=%b run=%b icount=%0d addr=%0d instr=%h, want 1 0 4 4 000",
               done, run, icount, addr, instr);
    end
    step();
    checks++;
    if (done !== 1'b1 || addr !== 10'd4) begin
      errors++;
      $display("FAIL straight_hold: done=%b addr=%0d, want 1 4", done, addr);
    end
  endtask

  task automatic test_restart();
    bit ok;
    start = 1'b1; step();
    checks++;
    if (done !== 1'b0 || run !== 1'b1 || addr !== 10'd0 || icount !== 16'd0) begin
      errors++;
      $display("FAIL restart_edge: done=%b run=%b addr=%0d icount=%0d, want 0 1 0 0",
               done, run, addr, icount);
    end
    step(); step();
    checks++;
    if (addr !== 10'd2 || icount !== 16'd2) begin
      errors++;
      $display("FAIL restart_start_held: addr=%0d icount=%0d, want 2 2", addr, icount);
    end
    start = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok || icount !== 16'd4 || addr !== 10'd4) begin
      errors++;
      $display("FAIL restart_halt: done=%b icount=%0d addr=%0d, want 1 4 4", done, icount, addr);
    end
  endtask

  task automatic test_branches();
    bit ok;
    logic [1:0] br_t [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic       sc_t [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [9:0] ex_t [6] = '{10'd20, 10'd3, 10'd20, 10'd3, 10'd20, 10'd20};
    lut_we = 1'b1; lut_idx = 4'd3; lut_data = 10'd20;
    step();
    lut_we = 1'b0;
    for (int t = 0; t < 6; t++) begin
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      branch = br_t[t]; sc = sc_t[t]; tlut = 4'd3;
      step();
      checks++;
      if (addr !== ex_t[t]) begin
        errors++;
        $display("FAIL branch_case%0d: Branch=%b sc=%b pc=%0d, want %0d", t, br_t[t], sc_t[t], addr, ex_t[t]);
      end
      branch = 2'b00; sc = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL branch_halt%0d: done=%b, want 1", t, done);
      end
    end
    branch = 2'b11; sc = 1'b1; tlut = 4'd3;
    step(); step();
    checks++;
    if (addr !== 10'd20 || done !== 1'b1) begin
      errors++;
      $display("FAIL branch_in_halt: addr=%0d done=%b, want 20 1", addr, done);
    end
    branch = 2'b00; sc = 1'b0;
  endtask

  task automatic test_lut_guard();
    bit ok;
    pulse_reset();
    start = 1'b1; step(); start = 1'b0;
    lut_we = 1'b1; lut_idx = 4'd7; lut_data = 10'd9;
    step();
    lut_we = 1'b0;
    branch = 2'b11; tlut = 4'd7;
    step();
    checks++;
    if (addr !== 10'd0) begin
      errors++;
      $display("FAIL lut_write_in_run: LUT[7] target=%0d, want 0", addr);
    end
    branch = 2'b00;
    wait_done(ok);
    pulse_reset();
    lut_we = 1'b1; lut_idx = 4'd7; lut_data = 10'd9;
    step();
    lut_we = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    branch = 2'b11; tlut = 4'd7;
    step();
    checks++;
    if (addr !== 10'd9) begin
      errors++;
      $display("FAIL lut_write_in_idle: LUT[7] target=%0d, want 9", addr);
    end
    branch = 2'b00;
    wait_done(ok);
    checks++;
    if (!ok || icount !== 16'd2) begin
      errors++;
      $display("FAIL lut_halt: done=%b icount=%0d, want 1 2", done, icount);
    end
  endtask

  task automatic test_wrap();
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (addr2 !== 4'(k) || icount2 !== 16'(k) || run2 !== 1'b1) begin
        errors++;
        $display("FAIL wrap_step%0d: pc=%0d icount=%0d run=%b, want %0d %0d 1",
                 k, addr2, icount2, run2, k % 16, k);
      end
      step();
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    branch = 2'b00; tlut = 4'd0; sc = 1'b0;
    lut_we = 1'b0; lut_idx = 4'd0; lut_data = 10'd0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h1A5;
    for (int i = 0; i < 16; i++) rom2[i] = 9'h0C3;
    rom[10] = 9'h000;
    rom[20] = 9'h000;
    #12;
    test_reset();
    test_straight();
    test_restart();
    test_branches();
    test_lut_guard();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
